// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states and the
// MDU result FIFO entry. Entry fields are sized for the widest supported port.
package wb_arb_pkg;

  localparam int ARB_ADDR_MAX = 16;
  localparam int ARB_DATA_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ARB_ADDR_MAX-1:0] addr;
    logic [ARB_DATA_MAX-1:0] data;
  } arb_entry_t;

endpackage

// File: rtl/wb_arb_if.sv
// Bundle of the pipeline WB request, MDU completion and shared register-file
// write port seen by the arbiter.
interface wb_arb_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;

  // MDU completion transfers on a cycle where mdu_valid and mdu_ready are both
  // high; mdu_valid must not wait on mdu_ready, and mdu_ready depends only on
  // registered state, so there is no combinational path between them.
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    input  wb_stall, mdu_ready, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    output wb_stall, mdu_ready, rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// Two-entry compacting FIFO of buffered MDU results: slot 0 is always the head,
// and entries squashed by a younger pipeline write are removed in place.
module wb_arb_fifo
  import wb_arb_pkg::*;
(
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_pop,
  input  logic                    i_push,
  input  arb_entry_t              i_push_ent,
  input  logic                    i_sq_en,
  input  logic [ARB_ADDR_MAX-1:0] i_sq_addr,
  output arb_entry_t              o_head,
  output logic [1:0]              o_count,
  output logic [1:0]              o_count_nxt,
  output logic                    o_sq_head,
  output logic [1:0]              o_sq_cnt
);

  arb_entry_t r_slot0;
  arb_entry_t r_slot1;
  arb_entry_t w_nxt0;
  arb_entry_t w_nxt1;
  arb_entry_t w_new;
  logic       w_sq0;
  logic       w_sq1;
  logic       w_keep0;
  logic       w_keep1;

  always_comb begin
    w_sq0   = i_sq_en && r_slot0.valid && !i_pop && (r_slot0.addr == i_sq_addr);
    w_sq1   = i_sq_en && r_slot1.valid && (r_slot1.addr == i_sq_addr);
    w_keep0 = r_slot0.valid && !i_pop && !w_sq0;
    w_keep1 = r_slot1.valid && !w_sq1;
    w_new   = '0;
    if (i_push) begin
      w_new       = i_push_ent;
      w_new.valid = 1'b1;
    end
    // Survivors shift toward slot 0, the new entry lands behind them.
    w_nxt0 = '0;
    w_nxt1 = '0;
    if (w_keep0) begin
      w_nxt0 = r_slot0;
      w_nxt1 = w_keep1 ? r_slot1 : w_new;
    end else if (w_keep1) begin
      w_nxt0 = r_slot1;
      w_nxt1 = w_new;
    end else begin
      w_nxt0 = w_new;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_slot0 <= w_nxt0;
      r_slot1 <= w_nxt1;
    end
  end

  assign o_head      = r_slot0;
  assign o_count     = {1'b0, r_slot0.valid} + {1'b0, r_slot1.valid};
  assign o_count_nxt = {1'b0, w_nxt0.valid} + {1'b0, w_nxt1.valid};
  assign o_sq_head   = w_sq0;
  assign o_sq_cnt    = {1'b0, w_sq0} + {1'b0, w_sq1};

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the pipeline WB stage and
// buffered MDU results; WB_ARB_PERF_CNT_EN adds force/drop event counters.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  wb_arb_if.slave    bus,
  output arb_state_t o_dbg_state
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_force_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_wait;
  logic [CNT_W-1:0]  w_wait_nxt;

  logic              w_issue;
  logic              w_accept;
  logic              w_suppress;
  logic              w_push;
  logic              w_pop;
  logic              w_blocked;
  logic              w_starved;
  arb_entry_t        w_push_ent;
  arb_entry_t        w_head;
  logic [1:0]        w_count;
  logic [1:0]        w_count_nxt;
  logic              w_sq_head;
  logic [1:0]        w_sq_cnt;
  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_addr;
  logic [DATA_W-1:0] w_rf_data;
  logic              w_unused;

  // The pipeline write only reaches the register file when not stalled.
  assign w_issue    = bus.wb_we && (r_state != FORCE);
  assign w_accept   = bus.mdu_valid && (w_count != 2'd2);
  assign w_suppress = w_accept && w_issue && (bus.mdu_addr != '0) &&
                      (bus.mdu_addr == bus.wb_addr);
  assign w_push     = w_accept && (bus.mdu_addr != '0) && !w_suppress;
  assign w_pop      = (r_state == FORCE) || ((r_state == PEND) && !bus.wb_we);
  assign w_blocked  = (r_state == PEND) && bus.wb_we && !w_sq_head;

  always_comb begin
    w_push_ent       = '0;
    w_push_ent.valid = 1'b1;
    w_push_ent.addr  = ARB_ADDR_MAX'(bus.mdu_addr);
    w_push_ent.data  = ARB_DATA_MAX'(bus.mdu_data);
  end

  wb_arb_fifo u_fifo (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_pop       (w_pop),
    .i_push      (w_push),
    .i_push_ent  (w_push_ent),
    .i_sq_en     (w_issue),
    .i_sq_addr   (ARB_ADDR_MAX'(bus.wb_addr)),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt),
    .o_sq_head   (w_sq_head),
    .o_sq_cnt    (w_sq_cnt)
  );

  // Wait counter tracks how long the current head has been refused the port.
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_pop || w_sq_head) begin
      w_wait_nxt = '0;
    end else if (w_blocked) begin
      w_wait_nxt = r_wait + 1'b1;
    end
  end

  assign w_starved = w_blocked && (w_wait_nxt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_count_nxt != 2'd0) w_state_nxt = PEND;
      end
      PEND: begin
        if (w_count_nxt == 2'd0) begin
          w_state_nxt = IDLE;
        end else if (w_starved) begin
          w_state_nxt = FORCE;
        end
      end
      FORCE: begin
        w_state_nxt = (w_count_nxt != 2'd0) ? PEND : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_addr = bus.wb_addr;
    w_rf_data = bus.wb_data;
    case (r_state)
      IDLE: w_rf_we = bus.wb_we;
      PEND: begin
        w_rf_we = 1'b1;
        if (!bus.wb_we) begin
          w_rf_addr = w_head.addr[ADDR_W-1:0];
          w_rf_data = w_head.data[DATA_W-1:0];
        end
      end
      FORCE: begin
        w_rf_we   = 1'b1;
        w_rf_addr = w_head.addr[ADDR_W-1:0];
        w_rf_data = w_head.data[DATA_W-1:0];
      end
      default: w_rf_we = 1'b0;
    endcase
  end

  // Reset must silence the write port even while a pipeline write is offered.
  assign bus.rf_we     = aresetn && w_rf_we;
  assign bus.rf_addr   = w_rf_addr;
  assign bus.rf_data   = w_rf_data;
  assign bus.wb_stall  = (r_state == FORCE);
  assign bus.mdu_ready = (w_count != 2'd2);
  assign o_dbg_state   = r_state;

  assign w_unused = &{1'b0, w_head, w_sq_cnt};

`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] r_perf_force;
  logic [31:0] r_perf_drop;
  logic [2:0]  w_drop_inc;
  logic [32:0] w_drop_sum;

  assign w_drop_inc = {1'b0, w_sq_cnt} + {2'b00, w_suppress};
  assign w_drop_sum = {1'b0, r_perf_drop} + {30'd0, w_drop_inc};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_perf_force <= '0;
      r_perf_drop  <= '0;
    end else begin
      if ((r_state == FORCE) && (r_perf_force != '1)) begin
        r_perf_force <= r_perf_force + 32'd1;
      end
      r_perf_drop <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end
  end

  assign perf_force_cnt = r_perf_force;
  assign perf_drop_cnt  = r_perf_drop;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;

  wb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] perf_force_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  wb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .aclk        (clk),
    .aresetn     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef WB_ARB_PERF_CNT_EN
    ,
    .perf_force_cnt (perf_force_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int  m_wait;
  bit  m_force;
  int  m_forces;
  int  m_drops;
  int  n_cmp;
  int  n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q    = {};
    m_wait   = 0;
    m_force  = 1'b0;
    m_forces = 0;
    m_drops  = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    @(negedge clk);
    bus.wb_we     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.mdu_valid = mv;
    bus.mdu_addr  = ma;
    bus.mdu_data  = md;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.wb_we   = 1'b1;
    bus.wb_addr = 7'd5;
    bus.mdu_valid = 1'b0;
    #1;
    check_eq("rst_rf_we", bus.rf_we, 1'b0);
    check_eq("rst_stall", bus.wb_stall, 1'b0);
    check_eq("rst_ready", bus.mdu_ready, 1'b1);
    check_eq("rst_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    bus.wb_we = 1'b0;
    rst_n     = 1'b1;
    model_clear();
  endtask

  // Predicts this cycle's outputs from the queue model, then advances it.
  task automatic model_step();
    logic [AW+DW-1:0] keep_q[$];
    logic             exp_we;
    logic [AW-1:0]    exp_addr;
    logic [DW-1:0]    exp_data;
    logic             issue;
    logic             popped;
    logic             head_gone;
    logic             ready;
    arb_state_t       exp_st;
    int               n;

    n     = exp_q.size();
    ready = (n < 2);
    if (m_force)    exp_st = FORCE;
    else if (n > 0) exp_st = PEND;
    else            exp_st = IDLE;
    check_eq("state", dbg_state, exp_st);
    check_eq("wb_stall", bus.wb_stall, m_force);
    check_eq("mdu_ready", bus.mdu_ready, ready);

    issue = 1'b0; popped = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    if (m_force) begin
      exp_we = 1'b1; {exp_addr, exp_data} = exp_q[0]; popped = 1'b1;
    end else if (bus.wb_we) begin
      exp_we = 1'b1; exp_addr = bus.wb_addr; exp_data = bus.wb_data; issue = 1'b1;
    end else if (n > 0) begin
      exp_we = 1'b1; {exp_addr, exp_data} = exp_q[0]; popped = 1'b1;
    end
    check_eq("rf_we", bus.rf_we, exp_we);
    if (exp_we) begin
      check_eq("rf_addr", bus.rf_addr, exp_addr);
      check_eq("rf_data", bus.rf_data, exp_data);
    end

    if (m_force) m_forces++;
    head_gone = popped;
    if (popped) void'(exp_q.pop_front());
    if (issue) begin
      foreach (exp_q[i]) begin
        if (exp_q[i][AW+DW-1:DW] == bus.wb_addr) begin
          m_drops++;
          if (i == 0) head_gone = 1'b1;
        end else begin
          keep_q.push_back(exp_q[i]);
        end
      end
      exp_q = keep_q;
    end
    if (bus.mdu_valid && ready && bus.mdu_addr != '0) begin
      if (issue && bus.mdu_addr == bus.wb_addr) m_drops++;
      else exp_q.push_back({bus.mdu_addr, bus.mdu_data});
    end

    if (head_gone)            m_wait = 0;
    else if (issue && n > 0)  m_wait++;
    m_force = !m_force && issue && (n > 0) && !head_gone && (m_wait == LIM);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    model_clear();
    rst_n = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_addr = '0; bus.mdu_data = '0;
    do_reset();

    // Idle pass-through.
    drive(1'b1, 7'd5, 32'h1234, 1'b0, 7'd0, 32'h0);
    check_eq("pass_we", bus.rf_we, 1'b1);
    check_eq("pass_addr", bus.rf_addr, 7'd5);
    check_eq("pass_data", bus.rf_data, 32'h1234);
    check_eq("pass_stall", bus.wb_stall, 1'b0);
    model_step();

    // MDU drain on an idle pipeline.
    drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd8, 32'hAA);
    check_eq("drain_early", bus.rf_we, 1'b0);
    model_step();
    drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
    check_eq("drain_addr", bus.rf_addr, 7'd8);
    check_eq("drain_data", bus.rf_data, 32'hAA);
    model_step();
    drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
    check_eq("drain_empty", dbg_state, IDLE);
    model_step();

    // Starvation: four blocked cycles then a single forced write.
    do_reset();
    drive(1'b1, 7'd1, 32'h11, 1'b1, 7'd9, 32'h55);
    model_step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 7'(k + 2), $urandom, 1'b0, 7'd0, 32'h0);
      check_eq("starve_nostall", bus.wb_stall, 1'b0);
      model_step();
    end
    drive(1'b1, 7'd6, 32'h66, 1'b0, 7'd0, 32'h0);
    check_eq("starve_stall", bus.wb_stall, 1'b1);
    check_eq("starve_addr", bus.rf_addr, 7'd9);
    check_eq("starve_data", bus.rf_data, 32'h55);
    model_step();
    drive(1'b1, 7'd7, 32'h77, 1'b0, 7'd0, 32'h0);
    check_eq("starve_release", bus.wb_stall, 1'b0);
    check_eq("starve_pass", bus.rf_addr, 7'd7);
    model_step();

    // WAW squash of a buffered entry.
    do_reset();
    drive(1'b1, 7'd1, 32'h1, 1'b1, 7'd3, 32'h77);
    model_step();
    drive(1'b1, 7'd3, 32'h99, 1'b0, 7'd0, 32'h0);
    check_eq("waw_data", bus.rf_data, 32'h99);
    model_step();
    drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
    check_eq("waw_gone", bus.rf_we, 1'b0);
    model_step();
`ifdef WB_ARB_PERF_CNT_EN
    check_eq("waw_drop_cnt", perf_drop_cnt, 32'd1);
`endif

    // Full FIFO back-pressure.
    do_reset();
    drive(1'b1, 7'd1, 32'h1, 1'b1, 7'd10, 32'hA0);
    model_step();
    drive(1'b1, 7'd2, 32'h2, 1'b1, 7'd11, 32'hB0);
    check_eq("full_ready1", bus.mdu_ready, 1'b1);
    model_step();
    drive(1'b1, 7'd4, 32'h4, 1'b0, 7'd0, 32'h0);
    check_eq("full_ready0", bus.mdu_ready, 1'b0);
    model_step();
    drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
    check_eq("full_pop_ready", bus.mdu_ready, 1'b0);
    check_eq("full_pop_addr", bus.rf_addr, 7'd10);
    model_step();
    drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
    check_eq("full_ready_back", bus.mdu_ready, 1'b1);
    model_step();

    // Asynchronous reset while forcing.
    do_reset();
    drive(1'b1, 7'd1, 32'h1, 1'b1, 7'd20, 32'hC0);
    model_step();
    drive(1'b1, 7'd2, 32'h2, 1'b1, 7'd21, 32'hC1);
    model_step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 7'(k + 3), 32'h3, 1'b0, 7'd0, 32'h0);
      model_step();
    end
    drive(1'b1, 7'd1, 32'h1, 1'b0, 7'd0, 32'h0);
    check_eq("arst_in_force", bus.wb_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_stall", bus.wb_stall, 1'b0);
    check_eq("arst_ready", bus.mdu_ready, 1'b1);
    check_eq("arst_state", dbg_state, IDLE);
    check_eq("arst_rf_we", bus.rf_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
    check_eq("arst_empty", bus.rf_we, 1'b0);
    model_step();

    // Randomized traffic in two pressure regimes.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        drive(($urandom_range(0, 99) < (ph == 0 ? 60 : 90)),
              7'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 99) < 50),
              7'($urandom_range(0, 15)), $urandom);
        model_step();
      end
    end
    @(negedge clk);
    #1;
`ifdef WB_ARB_PERF_CNT_EN
    check_eq("perf_force", perf_force_cnt, 32'(m_forces));
    check_eq("perf_drop", perf_drop_cnt, 32'(m_drops));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
